b_to_g_counter: RTL and testbench
=================================

Name: b_to_g_counter

Overview:
Binary up/down counter with a registered Gray-coded output. It is the encode-side companion of the team's 4-bit Gray-to-binary decoder. It produces Gray-coded counts/pointers, for example FIFO pointers and position encoders, whose value changes by exactly one bit per count step. The binary and Gray views are both registered and always describe the same count.

Parameters:
WIDTH, 4, counter and code width in bits (legal range 2..16)

Ports:
clk  input  1  rising-edge clock; single clock domain
rst  input  1  synchronous, active-high reset
en  input  1  count enable; one step per clk edge while high
up  input  1  direction: 1 = increment, 0 = decrement (sampled only when en=1)
load  input  1  synchronous load strobe
load_val  input  WIDTH  binary value to load
bin_out  output  WIDTH  registered binary count
gray_out  output  WIDTH  registered Gray code of bin_out
tc  output  1  combinational terminal count: the next enabled step wraps
wrap  output  1  registered one-cycle pulse: the previous cycle's step wrapped

Behaviour:
- Reset: on a clk edge with rst=1, bin_out=0, gray_out=0 and wrap=0. tc follows its own equation (it is 0 while en=0).
- Priority at each clk edge is rst > load > en. Inputs are ignored while rst=1.
- Load: with load=1 (rst=0), bin_out<=load_val and gray_out<=load_val^(load_val>>1), both on the same edge.
  - wrap<=0 on a load, even if en=1 and tc=1 in that cycle.
  - The load takes effect in one cycle; the loaded value is visible on the next edge.
- Count: with en=1, load=0 and rst=0:
  - next = up ? bin_out+1 : bin_out-1, computed modulo 2^WIDTH.
  - bin_out<=next and gray_out<=next^(next>>1) on the same edge, so the two outputs are never skewed.
- Hold: with en=0 and load=0, all registers hold and wrap<=0.
- Gray encoding: gray[WIDTH-1]=bin[WIDTH-1]; gray[i]=bin[i+1]^bin[i] for i<WIDTH-1.
  - gray_out is computed from the next binary value, not from the registered bin_out. This gives zero-latency agreement between bin_out and gray_out.
- tc = en & ~load & (up ? (bin_out==all-ones) : (bin_out==0)). It is combinational from the registers and the current inputs.
- wrap<=tc on every non-reset edge. It is a one-cycle pulse coincident with bin_out showing the wrapped value.
- Direction change: up may toggle on any cycle with no dead cycle. The step direction is taken from up in the same cycle as en.
- Single-bit-change property: across any count step, including the wrap in either direction, gray_out differs from its previous value in exactly one bit. This does not apply to load or reset.
- Reset mid-operation: a reset asserted during counting clears the count on that edge, with no partial step. Counting resumes from 0 on the first edge after rst drops.
- No X propagation: all outputs are defined from the first post-reset cycle.

Test Plan:
- Reset then hold: rst=1 for 2 cycles with en=1 and load=1 -> bin_out=0, gray_out=0, wrap=0. With rst=0 and en=0 for 3 cycles -> outputs unchanged.
- Up-count full cycle (WIDTH=4): en=1, up=1 for 17 cycles from 0 -> gray_out sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0,1. tc=1 only while bin_out=F. wrap pulses once, together with bin_out=0. Exactly one bit changes per step, including the 8->0 wrap.
- Down-count wrap: load load_val=1, then en=1, up=0 -> bin_out 1,0,F,E. gray_out 1,0,8,9. tc=1 while bin_out=0. wrap=1 in the cycle bin_out=F.
- Load priority: load=1, load_val=A, en=1, up=1, with bin_out=F (tc would fire) -> bin_out=A, gray_out=F, wrap=0, tc=0 during the load cycle.
- Direction flip: from bin_out=5, drive up=1,1,0,0,0 with en=1 -> bin_out 6,7,6,5,4 and gray_out 5,4,5,7,6. No skipped or held cycle.
- Mid-count reset: at bin_out=9 assert rst for 1 cycle with en=1 -> next bin_out=0, gray_out=0, wrap=0. The following cycle gives bin_out=1, gray_out=1.

Source files
------------

// File: rtl/b_to_g_counter.sv
// Binary up/down counter with a registered Gray view of the same count.
// Both views load from one next-value so they never disagree, even for a single cycle.
module b_to_g_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             tc,
    output logic             wrap
);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_wrap;
    logic [WIDTH-1:0] w_next;
    logic             w_at_top;
    logic             w_at_bottom;
    logic             w_tc;

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    always_comb begin
        w_next      = up ? (r_bin + WIDTH'(1)) : (r_bin - WIDTH'(1));
        w_at_top    = (r_bin == {WIDTH{1'b1}});
        w_at_bottom = (r_bin == '0);
        w_tc        = en & ~load & (up ? w_at_top : w_at_bottom);
    end

    // w_tc already folds in load and en, so it is exactly the next wrap pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin  <= '0;
            r_gray <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_tc;
            if (load) begin
                r_bin  <= load_val;
                r_gray <= bin2gray(load_val);
            end else if (en) begin
                r_bin  <= w_next;
                r_gray <= bin2gray(w_next);
            end
        end
    end

    assign bin_out  = r_bin;
    assign gray_out = r_gray;
    assign tc       = w_tc;
    assign wrap     = r_wrap;

endmodule

// File: tb/tb_b_to_g_counter.sv
// Bench for b_to_g_counter (WIDTH=4): directed vector table, full up-count sequence,
// and random traffic against an integer count model with a reflected Gray table.
module tb_b_to_g_counter;

    localparam int W = 4;
    localparam int N = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         up = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] bin_out;
    logic [W-1:0] gray_out;
    logic         tc;
    logic         wrap;

    int n_pass = 0;
    int n_total = 0;

    b_to_g_counter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .bin_out(bin_out), .gray_out(gray_out), .tc(tc), .wrap(wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic         r, e, u, l;
        logic [W-1:0] lv;
        logic         exp_tc;
        logic [W-1:0] exp_bin;
        logic [W-1:0] exp_gray;
        logic         exp_wrap;
    } vec_t;

    vec_t vecs[$];
    logic [W-1:0] gray_tbl[N];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s got %0h expected %0h", name, act, exp);
    endtask

    // Drive inputs just after a rising edge, sample tc before the next edge,
    // then step one clock and leave time 1 unit past the edge for output sampling.
    task automatic cycle(input logic r, input logic e, input logic u, input logic l,
                         input logic [W-1:0] lv, output logic tc_s);
        rst = r; en = e; up = u; load = l; load_val = lv;
        #1 tc_s = tc;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic r, e, u, l, input logic [W-1:0] lv,
                                input logic t, input logic [W-1:0] b, g, input logic w);
        vec_t v;
        v.r = r; v.e = e; v.u = u; v.l = l; v.lv = lv;
        v.exp_tc = t; v.exp_bin = b; v.exp_gray = g; v.exp_wrap = w;
        return v;
    endfunction

    initial begin
        logic         tc_s;
        logic [W-1:0] prev_gray;
        logic [W-1:0] up_gray[18];
        int           cnt;
        int           nxt;
        logic         m_tc;
        logic         m_wrap;
        logic         r, e, u, l;
        logic [W-1:0] lv;

        // Reflected construction: each new bit prefixes the mirrored previous list.
        gray_tbl[0] = '0;
        for (int k = 0; k < W; k++)
            for (int i = 0; i < (1 << k); i++)
                gray_tbl[(1 << k) + i] = W'(1 << k) | gray_tbl[(1 << k) - 1 - i];

        //            r  e  u  l  lv    tc  bin   gray  wrap
        vecs.push_back(mk(1, 1, 1, 1, 4'h7, 0, 4'h0, 4'h0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 4'h7, 0, 4'h0, 4'h0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 4'h0, 0, 4'h0, 4'h0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 4'h3, 0, 4'h0, 4'h0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 4'hF, 0, 4'h0, 4'h0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 4'h1, 0, 4'h1, 4'h1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 4'h0, 0, 4'h0, 4'h0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 4'h0, 1, 4'hF, 4'h8, 1));
        vecs.push_back(mk(0, 1, 0, 0, 4'h0, 0, 4'hE, 4'h9, 0));
        vecs.push_back(mk(0, 0, 0, 1, 4'hF, 0, 4'hF, 4'h8, 0));
        vecs.push_back(mk(0, 1, 1, 1, 4'hA, 0, 4'hA, 4'hF, 0));
        vecs.push_back(mk(0, 0, 0, 1, 4'h5, 0, 4'h5, 4'h7, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'h0, 0, 4'h6, 4'h5, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'h0, 0, 4'h7, 4'h4, 0));
        vecs.push_back(mk(0, 1, 0, 0, 4'h0, 0, 4'h6, 4'h5, 0));
        vecs.push_back(mk(0, 1, 0, 0, 4'h0, 0, 4'h5, 4'h7, 0));
        vecs.push_back(mk(0, 1, 0, 0, 4'h0, 0, 4'h4, 4'h6, 0));
        vecs.push_back(mk(0, 0, 0, 1, 4'h9, 0, 4'h9, 4'hD, 0));
        vecs.push_back(mk(1, 1, 1, 0, 4'h0, 0, 4'h0, 4'h0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'h0, 0, 4'h1, 4'h1, 0));

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].r, vecs[i].e, vecs[i].u, vecs[i].l, vecs[i].lv, tc_s);
            chk($sformatf("vec%0d_tc", i), 16'(tc_s), 16'(vecs[i].exp_tc));
            chk($sformatf("vec%0d_bin", i), 16'(bin_out), 16'(vecs[i].exp_bin));
            chk($sformatf("vec%0d_gray", i), 16'(gray_out), 16'(vecs[i].exp_gray));
            chk($sformatf("vec%0d_wrap", i), 16'(wrap), 16'(vecs[i].exp_wrap));
        end

        // Full up-count cycle from 0 including the wrap back to 0 and 1.
        up_gray = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                    4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0, 4'h1};
        cycle(1, 0, 0, 0, 4'h0, tc_s);
        chk("up_start_gray", 16'(gray_out), 16'(up_gray[0]));
        for (int s = 1; s <= 17; s++) begin
            prev_gray = gray_out;
            cycle(0, 1, 1, 0, 4'h0, tc_s);
            chk($sformatf("up%0d_tc", s), 16'(tc_s), 16'((s - 1) % N == N - 1));
            chk($sformatf("up%0d_bin", s), 16'(bin_out), 16'(s % N));
            chk($sformatf("up%0d_gray", s), 16'(gray_out), 16'(up_gray[s]));
            chk($sformatf("up%0d_wrap", s), 16'(wrap), 16'(s == N));
            chk($sformatf("up%0d_onebit", s), 16'($countones(prev_gray ^ gray_out)), 16'd1);
        end

        // Random traffic against an integer model of the count.
        cycle(1, 0, 0, 0, 4'h0, tc_s);
        cnt = 0;
        for (int s = 0; s < 400; s++) begin
            r  = ($urandom_range(0, 29) == 0);
            l  = ($urandom_range(0, 9) == 0);
            e  = ($urandom_range(0, 5) != 0);
            u  = $urandom_range(0, 1);
            lv = W'($urandom_range(0, N - 1));
            nxt = cnt + (u ? 1 : -1);
            m_tc = e && !l && (nxt < 0 || nxt >= N);
            prev_gray = gray_out;
            cycle(r, e, u, l, lv, tc_s);
            if (r) begin
                cnt = 0; m_wrap = 0;
            end else begin
                m_wrap = m_tc;
                if (l) cnt = int'(lv);
                else if (e) cnt = (nxt + N) % N;
            end
            chk($sformatf("rnd%0d_tc", s), 16'(tc_s), 16'(m_tc));
            chk($sformatf("rnd%0d_bin", s), 16'(bin_out), 16'(cnt));
            chk($sformatf("rnd%0d_gray", s), 16'(gray_out), 16'(gray_tbl[cnt]));
            chk($sformatf("rnd%0d_wrap", s), 16'(wrap), 16'(m_wrap));
            if (!r && !l && e)
                chk($sformatf("rnd%0d_onebit", s), 16'($countones(prev_gray ^ gray_out)), 16'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
